// File: rtl/param_control_core.sv
// Multi-cycle execute core: FETCH/EXEC/WB sequencing over a parametrised register file,
// producing ALU results, zero/carry flags and the next instruction pointer.
module param_control_core #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned IP_W      = 16,
    localparam int unsigned RSEL_W   = $clog2(REG_COUNT),
    localparam int unsigned INSTR_W  = 4 + 2 * (DATA_W + 1) + RSEL_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic [IP_W-1:0]    instruction_pointer,
    output logic               result_valid,
    output logic [DATA_W-1:0]  result_data,
    output logic [RSEL_W-1:0]  result_reg,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               halted,
    output logic               illegal
);

    localparam int unsigned OPW = DATA_W + 1;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_CMP  = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JZ   = 4'b1001;
    localparam logic [3:0] OP_JC   = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   capture_en, exec_en, wb_en;
    logic   ready_d, halted_d;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  regs_q [REG_COUNT];
    logic [DATA_W-1:0]  regs_d [REG_COUNT];
    logic [DATA_W-1:0]  res_q, res_d;
    logic               c_res_q, c_res_d;
    logic               jump_q, jump_d;
    logic [IP_W-1:0]    target_q, target_d;

    logic               ready_q, halted_q, illegal_q, illegal_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [RSEL_W-1:0]  rreg_q, rreg_d;
    logic               z_q, z_d, c_q, c_d;
    logic [IP_W-1:0]    ip_q, ip_d;

    // Field decode of the captured instruction
    logic [3:0]        op;
    logic [OPW-1:0]    fa, fb;
    logic [RSEL_W-1:0] dest;
    logic [DATA_W-1:0] opnd_a, opnd_b, alu;
    logic [DATA_W:0]   sum, diff;
    logic              alu_c, take_jump;
    logic              wr_op, upd_z, upd_c, is_illegal, is_halt;

    assign op   = instr_q[INSTR_W-1 -: 4];
    assign fa   = instr_q[INSTR_W-5 -: OPW];
    assign fb   = instr_q[INSTR_W-5-OPW -: OPW];
    assign dest = instr_q[RSEL_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (instr_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = is_halt ? S_HALT : S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        capture_en = (state_q == S_FETCH) && instr_valid;
        exec_en    = (state_q == S_EXEC);
        wb_en      = (state_q == S_WB);
        ready_d    = (state_d == S_FETCH);
        halted_d   = (state_d == S_HALT);
    end

    // Operand fetch and ALU evaluation, sampled into holding regs during EXEC
    always_comb begin
        opnd_a    = fa[OPW-1] ? regs_q[fa[RSEL_W-1:0]] : fa[DATA_W-1:0];
        opnd_b    = fb[OPW-1] ? regs_q[fb[RSEL_W-1:0]] : fb[DATA_W-1:0];
        sum       = {1'b0, opnd_a} + {1'b0, opnd_b};
        diff      = {1'b0, opnd_a} - {1'b0, opnd_b};
        alu       = '0;
        alu_c     = 1'b0;
        take_jump = 1'b0;
        case (op)
            OP_ADD:         begin alu = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
            OP_SUB, OP_CMP: begin alu = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
            OP_AND:         alu = opnd_a & opnd_b;
            OP_OR:          alu = opnd_a | opnd_b;
            OP_XOR:         alu = opnd_a ^ opnd_b;
            OP_MOV:         alu = opnd_a;
            OP_JMP:         take_jump = 1'b1;
            OP_JZ:          take_jump = z_q;
            OP_JC:          take_jump = c_q;
            default:        alu = '0;
        endcase
    end

    always_comb begin
        wr_op      = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                     (op == OP_OR)  || (op == OP_XOR) || (op == OP_MOV);
        upd_z      = wr_op || (op == OP_CMP);
        upd_c      = upd_z && (op != OP_MOV);
        is_halt    = (op == OP_HALT);
        is_illegal = (op == 4'b1011) || (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1110);
    end

    always_comb begin
        instr_d  = capture_en ? instruction : instr_q;
        res_d    = exec_en ? alu : res_q;
        c_res_d  = exec_en ? alu_c : c_res_q;
        jump_d   = exec_en ? take_jump : jump_q;
        target_d = exec_en ? IP_W'(opnd_a) : target_q;

        regs_d = regs_q;
        if (wb_en && wr_op) regs_d[dest] = res_q;

        rvalid_d  = wb_en && wr_op;
        rdata_d   = (wb_en && wr_op) ? res_q : rdata_q;
        rreg_d    = (wb_en && wr_op) ? dest : rreg_q;
        z_d       = (wb_en && upd_z) ? (res_q == '0) : z_q;
        c_d       = (wb_en && upd_c) ? c_res_q : c_q;
        ip_d      = wb_en ? (jump_q ? target_q : ip_q + IP_W'(1)) : ip_q;
        illegal_d = illegal_q || (wb_en && is_illegal);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q   <= '0;
            res_q     <= '0;
            c_res_q   <= 1'b0;
            jump_q    <= 1'b0;
            target_q  <= '0;
            for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
            ready_q   <= 1'b1;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rreg_q    <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            ip_q      <= '0;
        end else begin
            instr_q   <= instr_d;
            res_q     <= res_d;
            c_res_q   <= c_res_d;
            jump_q    <= jump_d;
            target_q  <= target_d;
            regs_q    <= regs_d;
            ready_q   <= ready_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rreg_q    <= rreg_d;
            z_q       <= z_d;
            c_q       <= c_d;
            ip_q      <= ip_d;
        end
    end

    assign instr_ready         = ready_q;
    assign halted              = halted_q;
    assign illegal             = illegal_q;
    assign result_valid        = rvalid_q;
    assign result_data         = rdata_q;
    assign result_reg          = rreg_q;
    assign flag_zero           = z_q;
    assign flag_carry          = c_q;
    assign instruction_pointer = ip_q;

endmodule

// File: doc/param_control_core.md
# param_control_core

Parametrised successor to the 8-bit control matrix: a multi-cycle execute core with a configurable-width, configurable-depth register file. It accepts one instruction per ready/valid handshake and runs it through an EXEC/WB state machine. It produces arithmetic/logic results, zero/carry flags and an instruction pointer for the instruction fetcher. The core sits between instruction memory (driven by `instruction_pointer`) and the register-file consumers on the soft-CPU datapath.

## Interface
- `DATA_W`, 8, datapath and register width (≥ 4)
- `REG_COUNT`, 16, number of registers (power of 2, ≥ 2); `RSEL_W = $clog2(REG_COUNT)`
- `IP_W`, 16, instruction pointer width
- Derived, not overridable: `INSTR_W = 4 + 2*(DATA_W+1) + RSEL_W` (26 at defaults)
- `clock` in 1: rising-edge clock
- `reset_n` in 1: asynchronous active-low reset
- `instr_valid` in 1: instruction present
- `instr_ready` out 1: core can accept (high only in FETCH)
- `instruction` in INSTR_W: opcode, opA, opB, dest
- `instruction_pointer` out IP_W: address of next instruction to present
- `result_valid` out 1: one-cycle pulse per register write
- `result_data` out DATA_W: last value written
- `result_reg` out RSEL_W: last destination index
- `flag_zero`, `flag_carry` out 1: status flags
- `halted` out 1: core stopped by HALT
- `illegal` out 1: sticky, undefined opcode seen

## Operation
- Field layout, MSB first:
  - `[INSTR_W-1 -: 4]`: opcode.
  - opA: DATA_W+1 bits.
  - opB: DATA_W+1 bits.
  - `[RSEL_W-1:0]`: dest.
- Operand MSB is a register flag:
  - 1: value = reg[low RSEL_W bits of the field].
  - 0: value = low DATA_W bits (immediate).
- Opcodes (A = opA value, B = opB value):
  - 0000 NOP.
  - 0001 ADD: dest=A+B, C=carry-out.
  - 0010 SUB: dest=A−B mod 2^DATA_W, C=borrow (A<B).
  - 0011 AND, 0100 OR, 0101 XOR: dest=A op B, C=0.
  - 0110 MOV: dest=A, C unchanged.
  - 0111 CMP: SUB flags only, no write.
  - 1000 JMP: IP=A zero-extended/truncated to IP_W.
  - 1001 JZ: jump if Z.
  - 1010 JC: jump if C.
  - 1111 HALT.
  - Any other opcode: acts as NOP and sets `illegal`.
- Z is updated on ADD/SUB/AND/OR/XOR/MOV/CMP (Z = result==0). Flags are unchanged on NOP, jumps and illegal opcodes.
- All REG_COUNT registers are writable, including reg 0.
- States:
  - FETCH → EXEC on handshake; the instruction is captured.
  - EXEC → WB: operands are read and the result/flags are computed into holding regs.
  - WB → FETCH: register write, flags, IP and `result_*` update at the WB edge.
  - WB → HALTED on HALT.
- HALTED is terminal until reset: `instr_ready`=0, `halted`=1, IP frozen.
- IP update at WB: taken jump loads the target; otherwise IP+1, wrapping from 2^IP_W−1 to 0.
- No hazards: the next instruction is accepted only after the write completes.

## Timing
- Reset (async, while `reset_n`=0):
  - All registers, flags, IP, `result_*`, `halted` and `illegal` go to 0.
  - State goes to FETCH, so `instr_ready` reads 1.
  - Handshakes are ignored while in reset.
- Reset mid-EXEC/WB: the in-flight instruction is discarded, with no register write and no `result_valid`.
- Handshake at edge E0. EXEC occupies the cycle after E0, WB the cycle after E1.
- At E2, the new state becomes visible:
  - `result_valid`=1 for exactly the cycle after E2, for writing opcodes only.
  - Flags and IP are updated.
  - `instr_ready`=1 again in that same cycle.
- Throughput: one instruction per 3 cycles when `instr_valid` is held high.
- `instr_valid` low in FETCH: the core idles with all outputs held.
- `result_data`/`result_reg` hold their values between writes.

## Test plan
- Reset; ADD imm 0x7F + imm 0x01 → r3:
  - `result_valid` appears 3 cycles after the handshake, with `result_data`=0x80 and `result_reg`=3.
  - Z=0, C=0, IP=1.
- ADD 0xFF+0x01 → r0 gives 0x00 with Z=1, C=1. Then SUB r0 − imm 1 → r1 gives 0xFF with C=1, Z=0.
- MOV imm 0x05 → r2, then ADD r2+r2 → r4 gives 0x0A (register-operand path); r2 still reads 0x05.
- CMP r2, imm 5:
  - Z=1, no `result_valid`, registers unchanged.
  - JZ 0x40 → IP=0x40.
  - JC not taken → IP=0x41.
  - Opcode 1100 → `illegal`=1, IP=0x42.
- Instance with IP_W=8: JMP 0xFF then NOP → IP wraps to 0x00.
- DATA_W=16, REG_COUNT=32 instance: ADD r31 (0xFFFF) + imm 1 → r5 gives 0x0000 with C=1.
- HALT → `halted`=1 and `instr_ready`=0 indefinitely.
- `reset_n` pulsed low during EXEC of an ADD → no write, all outputs 0, `instr_ready`=1 after release.
